// File: rtl/instruction_sequencer_pkg.sv
// Shared types for the instruction sequencer: instruction word layout, opcodes,
// fault codes and FSM states.
package instruction_sequencer_pkg;

    typedef struct packed {
        logic [7:0] op;
        logic [7:0] dev;
        logic [7:0] regaddr;
        logic [7:0] data;
    } st_instructionData;

    typedef enum logic [7:0] {
        OpNop   = 8'h00,
        OpI2cRd = 8'h01,
        OpI2cWr = 8'h02,
        OpDelay = 8'h03,
        OpEnd   = 8'hFF
    } e_opcode;

    typedef enum logic [3:0] {
        FaultNone   = 4'd0,
        FaultMem    = 4'd1,
        FaultOpcode = 4'd2,
        FaultNack   = 4'd3,
        FaultPcOvf  = 4'd4
    } e_fault;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StIssue,
        StWaitDone,
        StDelay,
        StDone,
        StFault
    } e_seq_state;

endpackage

// File: rtl/instruction_sequencer_if.sv
// Instruction-memory read port and I2C master request/completion signals.
// master = sequencer side, slave = memory plus I2C master side.
interface instruction_sequencer_if #(
    parameter int unsigned AddrW = 8
);
    logic [AddrW-1:0] reg_addr;
    logic [31:0]      read_data;
    logic [3:0]       error_code;

    logic             i2c_req_valid;
    logic             i2c_req_ready;
    logic             i2c_req_rw;
    logic [7:0]       i2c_dev;
    logic [7:0]       i2c_reg;
    logic [7:0]       i2c_wdata;
    logic             i2c_done;
    logic             i2c_ack_err;
    logic [7:0]       i2c_rdata;

    modport master (
        output reg_addr,
        input  read_data,
        input  error_code,
        output i2c_req_valid,
        input  i2c_req_ready,
        output i2c_req_rw,
        output i2c_dev,
        output i2c_reg,
        output i2c_wdata,
        input  i2c_done,
        input  i2c_ack_err,
        input  i2c_rdata
    );

    modport slave (
        input  reg_addr,
        output read_data,
        output error_code,
        input  i2c_req_valid,
        output i2c_req_ready,
        input  i2c_req_rw,
        input  i2c_dev,
        input  i2c_reg,
        input  i2c_wdata,
        output i2c_done,
        output i2c_ack_err,
        output i2c_rdata
    );
endinterface

// File: rtl/instruction_sequencer.sv
// Fetches and executes the stored program from address 0, driving I2C requests
// until END or a fault. Memory reads have one cycle of registered latency.
module instruction_sequencer
    import instruction_sequencer_pkg::*;
#(
    parameter int unsigned AddrW = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_ni,
    input  logic                     start_i,
    instruction_sequencer_if.master  bus,
    output logic                     rd_data_valid_o,
    output logic [7:0]               rd_data_o,
    output logic                     busy_o,
    output logic                     halted_o,
    output logic [3:0]               fault_code_o
);

    e_seq_state        state_q, state_d;
    logic [AddrW-1:0]  pc_q, pc_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        dev_q, dev_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        wdata_q, wdata_d;
    logic              rw_q, rw_d;
    logic              halted_q, halted_d;
    e_fault            fault_q, fault_d;
    logic [7:0]        rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              advance;
    st_instructionData instr;

    assign instr = st_instructionData'(bus.read_data);

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= StIdle;
            pc_q       <= '0;
            cnt_q      <= '0;
            dev_q      <= '0;
            reg_q      <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            halted_q   <= 1'b0;
            fault_q    <= FaultNone;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wdata_q    <= wdata_d;
            rw_q       <= rw_d;
            halted_q   <= halted_d;
            fault_q    <= fault_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        wdata_d    = wdata_q;
        rw_d       = rw_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        advance    = 1'b0;

        case (state_q)
            StIdle, StDone, StFault: begin
                if (start_i) begin
                    pc_d     = '0;
                    fault_d  = FaultNone;
                    halted_d = 1'b0;
                    state_d  = StFetch;
                end
            end
            StFetch: state_d = StDecode;
            StDecode: begin
                // A memory error outranks whatever opcode came back with it.
                if (bus.error_code != 4'd0) begin
                    fault_d = FaultMem;
                    state_d = StFault;
                end else begin
                    case (instr.op)
                        OpNop: advance = 1'b1;
                        OpI2cRd, OpI2cWr: begin
                            dev_d   = instr.dev;
                            reg_d   = instr.regaddr;
                            wdata_d = instr.data;
                            rw_d    = (instr.op == OpI2cRd);
                            state_d = StIssue;
                        end
                        OpDelay: begin
                            cnt_d   = instr.data;
                            state_d = StDelay;
                        end
                        OpEnd: begin
                            halted_d = 1'b1;
                            state_d  = StDone;
                        end
                        default: begin
                            fault_d = FaultOpcode;
                            state_d = StFault;
                        end
                    endcase
                end
            end
            StIssue: begin
                if (bus.i2c_req_ready) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (bus.i2c_done) begin
                    if (bus.i2c_ack_err) begin
                        fault_d = FaultNack;
                        state_d = StFault;
                    end else begin
                        if (rw_q) begin
                            rd_data_d  = bus.i2c_rdata;
                            rd_valid_d = 1'b1;
                        end
                        advance = 1'b1;
                    end
                end
            end
            StDelay: begin
                if (cnt_q == 8'd0) begin
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        // The program counter never wraps; running off the end is a fault.
        if (advance) begin
            if (pc_q == {AddrW{1'b1}}) begin
                fault_d = FaultPcOvf;
                state_d = StFault;
            end else begin
                pc_d    = pc_q + AddrW'(1);
                state_d = StFetch;
            end
        end
    end

    assign bus.reg_addr      = pc_q;
    assign bus.i2c_req_valid = (state_q == StIssue);
    assign bus.i2c_req_rw    = rw_q;
    assign bus.i2c_dev       = dev_q;
    assign bus.i2c_reg       = reg_q;
    assign bus.i2c_wdata     = wdata_q;

    assign rd_data_valid_o = rd_valid_q;
    assign rd_data_o       = rd_data_q;
    assign halted_o        = halted_q;
    assign fault_code_o    = fault_q;
    assign busy_o          = (state_q == StFetch) || (state_q == StDecode) ||
                             (state_q == StIssue) || (state_q == StWaitDone) ||
                             (state_q == StDelay);

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed bench: registered instruction memory model plus hand-driven I2C master.
module tb_instruction_sequencer;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic       rd_data_valid;
    logic [7:0] rd_data;
    logic       busy;
    logic       halted;
    logic [3:0] fault_code;

    logic [31:0] mem [256];
    int          mem_err_addr;
    int          n_checks;
    int          n_fail;

    instruction_sequencer_if #(.AddrW(8)) bus ();

    instruction_sequencer #(.AddrW(8)) dut (
        .clk_i           (clk),
        .reset_ni        (reset_n),
        .start_i         (start),
        .bus             (bus),
        .rd_data_valid_o (rd_data_valid),
        .rd_data_o       (rd_data),
        .busy_o          (busy),
        .halted_o        (halted),
        .fault_code_o    (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle registered memory read.
    always @(posedge clk) begin
        bus.read_data  <= mem[bus.reg_addr];
        bus.error_code <= (int'(bus.reg_addr) == mem_err_addr) ? 4'd1 : 4'd0;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_prog();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, bus.i2c_req_valid}, 32'd0);
        check_eq({tag, "_addr"}, {24'd0, bus.reg_addr}, 32'd0);
        check_eq({tag, "_dev"}, {24'd0, bus.i2c_dev}, 32'd0);
        check_eq({tag, "_reg"}, {24'd0, bus.i2c_reg}, 32'd0);
        check_eq({tag, "_wdata"}, {24'd0, bus.i2c_wdata}, 32'd0);
        check_eq({tag, "_rdv"}, {31'd0, rd_data_valid}, 32'd0);
        check_eq({tag, "_rdata"}, {24'd0, rd_data}, 32'd0);
        check_eq({tag, "_halted"}, {31'd0, halted}, 32'd0);
        check_eq({tag, "_fault"}, {28'd0, fault_code}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        mem_err_addr = -1;
        reset_n = 1'b0;
        start = 1'b0;
        bus.i2c_req_ready = 1'b0;
        bus.i2c_done = 1'b0;
        bus.i2c_ack_err = 1'b0;
        bus.i2c_rdata = 8'h00;
        clear_mem();
        ticks(3);
        reset_n = 1'b1;
        check_reset_outputs("rst");

        // NOP then END: halted five cycles after start, never a request.
        mem[1] = 32'hFF00_0000;
        start_prog();
        check_eq("nop_busy", {31'd0, busy}, 32'd1);
        for (int i = 1; i < 5; i++) begin
            check_eq("nop_nohalt", {31'd0, halted}, 32'd0);
            check_eq("nop_novalid", {31'd0, bus.i2c_req_valid}, 32'd0);
            tick();
        end
        check_eq("nop_halted", {31'd0, halted}, 32'd1);
        check_eq("nop_fault", {28'd0, fault_code}, 32'd0);
        check_eq("nop_idle", {31'd0, busy}, 32'd0);

        // Write with backpressure: payload stable while ready is low.
        mem[0] = 32'h021d_ab32;
        start_prog();
        ticks(2);
        for (int i = 0; i < 3; i++) begin
            check_eq("wr_valid", {31'd0, bus.i2c_req_valid}, 32'd1);
            check_eq("wr_dev", {24'd0, bus.i2c_dev}, 32'h1d);
            check_eq("wr_reg", {24'd0, bus.i2c_reg}, 32'hab);
            check_eq("wr_wdata", {24'd0, bus.i2c_wdata}, 32'h32);
            check_eq("wr_rw", {31'd0, bus.i2c_req_rw}, 32'd0);
            tick();
        end
        bus.i2c_req_ready = 1'b1;
        check_eq("wr_valid_acc", {31'd0, bus.i2c_req_valid}, 32'd1);
        tick();
        bus.i2c_req_ready = 1'b0;
        check_eq("wr_valid_drop", {31'd0, bus.i2c_req_valid}, 32'd0);
        check_eq("wr_wait_busy", {31'd0, busy}, 32'd1);
        bus.i2c_done = 1'b1;
        tick();
        bus.i2c_done = 1'b0;
        check_eq("wr_next_pc", {24'd0, bus.reg_addr}, 32'd1);
        check_eq("wr_no_rdv", {31'd0, rd_data_valid}, 32'd0);
        ticks(2);
        check_eq("wr_halted", {31'd0, halted}, 32'd1);

        // Read: result strobe in the cycle after done.
        mem[0] = 32'h011d_0f00;
        bus.i2c_req_ready = 1'b1;
        start_prog();
        ticks(2);
        check_eq("rd_valid", {31'd0, bus.i2c_req_valid}, 32'd1);
        check_eq("rd_rw", {31'd0, bus.i2c_req_rw}, 32'd1);
        check_eq("rd_reg", {24'd0, bus.i2c_reg}, 32'h0f);
        tick();
        check_eq("rd_valid_drop", {31'd0, bus.i2c_req_valid}, 32'd0);
        bus.i2c_done = 1'b1;
        bus.i2c_rdata = 8'h5A;
        tick();
        bus.i2c_done = 1'b0;
        check_eq("rd_strobe", {31'd0, rd_data_valid}, 32'd1);
        check_eq("rd_data", {24'd0, rd_data}, 32'h5A);
        check_eq("rd_fetch_next", {24'd0, bus.reg_addr}, 32'd1);
        tick();
        check_eq("rd_strobe_end", {31'd0, rd_data_valid}, 32'd0);
        tick();
        check_eq("rd_halted", {31'd0, halted}, 32'd1);

        // NACK on a write faults with code 3; a new start clears it.
        mem[0] = 32'h021d_ab32;
        start_prog();
        ticks(3);
        bus.i2c_done = 1'b1;
        bus.i2c_ack_err = 1'b1;
        tick();
        bus.i2c_done = 1'b0;
        bus.i2c_ack_err = 1'b0;
        check_eq("nack_fault", {28'd0, fault_code}, 32'd3);
        check_eq("nack_busy", {31'd0, busy}, 32'd0);
        check_eq("nack_halted", {31'd0, halted}, 32'd0);
        mem[0] = 32'hFF00_0000;
        start_prog();
        check_eq("nack_clear", {28'd0, fault_code}, 32'd0);
        ticks(2);
        check_eq("restart_halted", {31'd0, halted}, 32'd1);

        // Illegal opcode.
        mem[0] = 32'h0700_0000;
        start_prog();
        ticks(1);
        check_eq("ill_pre", {28'd0, fault_code}, 32'd0);
        tick();
        check_eq("ill_fault", {28'd0, fault_code}, 32'd2);

        // Memory error wins over the (valid) opcode.
        mem[0] = 32'h0000_0000;
        mem_err_addr = 0;
        start_prog();
        ticks(2);
        check_eq("mem_fault", {28'd0, fault_code}, 32'd1);
        mem_err_addr = -1;

        // DELAY 3: four cycles parked at pc 0, then fetch of pc 1.
        mem[0] = 32'h0300_0003;
        start_prog();
        ticks(2);
        for (int i = 0; i < 4; i++) begin
            check_eq("dly_hold", {24'd0, bus.reg_addr}, 32'd0);
            check_eq("dly_busy", {31'd0, busy}, 32'd1);
            tick();
        end
        check_eq("dly_next", {24'd0, bus.reg_addr}, 32'd1);
        ticks(2);
        check_eq("dly_halted", {31'd0, halted}, 32'd1);

        // All-NOP memory: advancing past the last address faults with 4.
        clear_mem();
        start_prog();
        ticks(511);
        check_eq("ovf_last_pc", {24'd0, bus.reg_addr}, 32'd255);
        check_eq("ovf_pre", {28'd0, fault_code}, 32'd0);
        tick();
        check_eq("ovf_fault", {28'd0, fault_code}, 32'd4);
        check_eq("ovf_busy", {31'd0, busy}, 32'd0);

        // Reset during WAIT_DONE; a later done must be ignored.
        mem[0] = 32'h011d_0f00;
        mem[1] = 32'hFF00_0000;
        start_prog();
        ticks(3);
        check_eq("rst_wait_busy", {31'd0, busy}, 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check_reset_outputs("rst_mid");
        bus.i2c_done = 1'b1;
        bus.i2c_rdata = 8'h33;
        tick();
        bus.i2c_done = 1'b0;
        bus.i2c_req_ready = 1'b0;
        check_eq("rst_done_rdv", {31'd0, rd_data_valid}, 32'd0);
        check_eq("rst_done_rdata", {24'd0, rd_data}, 32'd0);
        check_eq("rst_done_busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
